// File: rtl/aespim_inv_cipher_if.sv
// aespim inverse cipher port bundle: block start/result
// handshake plus the round-key request/valid channel.
interface aespim_inv_cipher_if;
  logic         start_i;
  logic [127:0] data_i;
  logic         ready_o;
  logic         rk_req_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         rk_valid_i;
  logic [127:0] data_o;
  logic         valid_o;

  modport master (
    output start_i, data_i, rk_i, rk_valid_i,
    input  ready_o, rk_req_o, rk_idx_o, data_o, valid_o
  );

  modport slave (
    input  start_i, data_i, rk_i, rk_valid_i,
    output ready_o, rk_req_o, rk_idx_o, data_o, valid_o
  );
endinterface

// File: rtl/aespim_inv_cipher.sv
// aespim inverse cipher: iterative column-serial AES decryption
// fetching round keys last-first over a req/valid port.
package aespim_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [31:0] o;
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    o = '0;
    for (int r = 0; r < 4; r++) begin
      o = {o[23:0],
           gmul(a[2'(r)],     8'h0e) ^
           gmul(a[2'(r + 1)], 8'h0b) ^
           gmul(a[2'(r + 2)], 8'h0d) ^
           gmul(a[2'(r + 3)], 8'h09)};
    end
    return o;
  endfunction
endpackage

module aespim_bSbox (
  input  logic       encrypt,
  input  logic [7:0] a,
  output logic [7:0] q
);
  import aespim_pkg::*;

  logic [7:0] x, x2, x3, x12, x15, x240, inv, y;

  // GF(2^8) inverse as x^254, wrapped by the forward or inverse affine map
  always_comb begin
    x = encrypt ? a :
        ({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^
         {a[1:0], a[7:2]} ^ 8'h05);
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    q = encrypt ? y : inv;
  end
endmodule

module aespim_inv_cipher #(
  parameter int unsigned NR = 10
) (
  input logic                clk_i,
  input logic                rst_ni,
  aespim_inv_cipher_if.slave bus
);
  import aespim_pkg::*;

  typedef enum logic [2:0] {IDLE, ARK, SUB, MIX, DONE} state_e;

  localparam logic [3:0] NRV = 4'(NR);

  state_e       fsm, nxt;
  logic [3:0]   rnd;
  logic [1:0]   k;
  logic [127:0] st;
  logic [127:0] dout;
  logic [95:0]  shd;
  logic [7:0]   sb     [16];
  logic [7:0]   sb_in  [4];
  logic [7:0]   sb_out [4];
  logic [31:0]  col    [4];
  logic [31:0]  sb_col;
  logic [31:0]  mc_out;
  logic         hs;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sb[i] = st[127 - 8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign col[c] = st[127 - 32*c -: 32];
  end

  for (genvar r = 0; r < 4; r++) begin : g_sb
    assign sb_in[r] = sb[{k - 2'(r), 2'(r)}];
    aespim_bSbox u_sbox (
      .encrypt (1'b0),
      .a       (sb_in[r]),
      .q       (sb_out[r])
    );
  end

  assign sb_col = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
  assign mc_out = inv_mix(col[k]);
  assign hs     = (fsm == ARK) && bus.rk_valid_i;

  assign bus.ready_o  = (fsm == IDLE);
  assign bus.rk_req_o = (fsm == ARK);
  assign bus.rk_idx_o = (fsm == ARK) ? rnd : 4'd0;
  assign bus.valid_o  = (fsm == DONE);
  assign bus.data_o   = dout;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fsm <= IDLE;
    else         fsm <= nxt;
  end

  // next-state: ARK branches on round position, SUB/MIX span four columns
  always_comb begin
    nxt = fsm;
    unique case (fsm)
      IDLE: if (bus.start_i) nxt = ARK;
      ARK: begin
        if (hs) begin
          if (rnd == NRV)     nxt = SUB;
          else if (rnd == '0) nxt = DONE;
          else                nxt = MIX;
        end
      end
      SUB:  if (k == 2'd3) nxt = ARK;
      MIX:  if (k == 2'd3) nxt = SUB;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // datapath: load, key add, shadowed InvSubBytes, in-place InvMixColumns
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rnd  <= '0;
      k    <= '0;
      st   <= '0;
      shd  <= '0;
      dout <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (bus.start_i) begin
            st  <= bus.data_i;
            rnd <= NRV;
            k   <= '0;
          end
        end
        ARK: begin
          if (hs) begin
            st <= st ^ bus.rk_i;
            if (rnd == NRV) rnd  <= rnd - 4'd1;
            if (rnd == '0)  dout <= st ^ bus.rk_i;
          end
        end
        SUB: begin
          k <= k + 2'd1;
          if (k == 2'd3) st <= {shd, sb_col};
          else shd[{2'd2 - k, 5'h1f} -: 32] <= sb_col;
        end
        MIX: begin
          k <= k + 2'd1;
          st[{~k, 5'h1f} -: 32] <= mc_out;
          if (k == 2'd3) rnd <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aespim_inv_cipher.sv
// Bench for aespim_inv_cipher: known-answer blocks and random
// blocks encrypted by a forward AES-128 model kept here.
module tb_aespim_inv_cipher;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  aespim_inv_cipher_if bif();

  aespim_inv_cipher #(.NR(10)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bif)
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nbad = 0;

  logic [127:0] rk_tab [11];
  logic [7:0]   sbox [256];
  int           dly = 0;
  int           wcnt = 0;
  bit           spur_en = 1'b0;
  logic         spur_tog = 1'b0;
  logic [3:0]   idxq [$];

  // key-store responder: waits dly cycles per request (0 = same cycle)
  always_comb begin
    bif.rk_valid_i = 1'b0;
    bif.rk_i = '1;
    if (bif.rk_req_o) begin
      bif.rk_valid_i = (wcnt >= dly);
      if (bif.rk_valid_i) bif.rk_i = rk_tab[bif.rk_idx_o];
    end else if (spur_en) begin
      bif.rk_valid_i = spur_tog;
    end
  end

  always @(posedge clk_i) begin
    if (bif.rk_req_o && !bif.rk_valid_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bif.rk_req_o && bif.rk_valid_i) idxq.push_back(bif.rk_idx_o);
  end

  always @(negedge clk_i) spur_tog <= spur_en & 1'($urandom);

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] x, input int i);
    return x[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int c, r;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      c = i / 4;
      r = i % 4;
      o = {o[119:0], sbox[gb(s, 4*((c + r) % 4) + r)]};
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(s, 4*c + r);
      for (int r = 0; r < 4; r++)
        o = {o[119:0], gm(a[r], 8'h02) ^ gm(a[(r + 1) % 4], 8'h03) ^
                       a[(r + 2) % 4] ^ a[(r + 3) % 4]};
    end
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
            ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r < 10) s = mix(s);
      s = s ^ rk_tab[r];
    end
    return s;
  endfunction

  task automatic run_op(input logic [127:0] ct, input int d, input bit poke,
                        output logic [127:0] res, output int lat,
                        output int npulse);
    dly = d;
    lat = 0;
    npulse = 0;
    @(negedge clk_i);
    bif.start_i = 1'b1;
    bif.data_i = ct;
    @(posedge clk_i);
    #1;
    bif.start_i = 1'b0;
    bif.data_i = ~ct;
    while (lat < 400) begin
      bif.start_i = poke && (lat == 4 || lat == 39);
      @(posedge clk_i);
      #1;
      lat++;
      bif.start_i = 1'b0;
      if (bif.valid_o) break;
    end
    check("valid_seen", 128'(bif.valid_o), 128'(1));
    res = bif.data_o;
    npulse = int'(bif.valid_o);
    check("ready_in_done", 128'(bif.ready_o), 128'(0));
    bif.start_i = poke;
    @(posedge clk_i);
    #1;
    bif.start_i = 1'b0;
    npulse += int'(bif.valid_o);
    check("ready_after_done", 128'(bif.ready_o), 128'(1));
    check("data_hold", bif.data_o, res);
  endtask

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, key, pt, ct, obs, exp;
    int lat, np, d;

    bif.start_i = 1'b0;
    bif.data_i = '0;
    build_sbox();
    expand(K1);

    #12;
    check("rst_ready", 128'(bif.ready_o), 128'(1));
    check("rst_rk_req", 128'(bif.rk_req_o), 128'(0));
    check("rst_rk_idx", 128'(bif.rk_idx_o), 128'(0));
    check("rst_data", bif.data_o, 128'(0));
    check("rst_valid", 128'(bif.valid_o), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(C1, 0, 1'b0, res, lat, np);
    check("t1_data", res, P1);
    check("t1_lat", 128'(lat), 128'(87));
    check("t1_pulses", 128'(np), 128'(1));

    expand(K2);
    check("t2_rk10_tab", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    idxq.delete();
    run_op(C2, 0, 1'b0, res, lat, np);
    check("t2_data", res, P2);
    check("t2_nkeys", 128'(idxq.size()), 128'(11));
    obs = '0;
    exp = '0;
    foreach (idxq[i]) obs = {obs[123:0], idxq[i]};
    for (int i = 0; i < 11; i++) exp = {exp[123:0], 4'(10 - i)};
    check("t2_idx_seq", obs, exp);

    expand(128'h0);
    run_op(C3, 3, 1'b0, res, lat, np);
    check("t3_data", res, 128'h0);
    check("t3_lat", 128'(lat), 128'(120));

    expand(K1);
    run_op(C1, 0, 1'b1, res, lat, np);
    check("t4_data", res, P1);
    check("t4_lat", 128'(lat), 128'(87));
    check("t4_pulses", 128'(np), 128'(1));
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = encrypt(pt);
    run_op(ct, 0, 1'b0, res, lat, np);
    check("t4_b2b_data", res, pt);
    check("t4_b2b_lat", 128'(lat), 128'(87));

    @(negedge clk_i);
    bif.start_i = 1'b1;
    bif.data_i = C1;
    @(posedge clk_i);
    #1;
    bif.start_i = 1'b0;
    repeat (29) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t5_ready", 128'(bif.ready_o), 128'(1));
    check("t5_rk_req", 128'(bif.rk_req_o), 128'(0));
    check("t5_data", bif.data_o, 128'(0));
    check("t5_valid", 128'(bif.valid_o), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    expand(K2);
    run_op(C2, 0, 1'b0, res, lat, np);
    check("t5_new_data", res, P2);
    check("t5_new_lat", 128'(lat), 128'(87));

    expand(K1);
    spur_en = 1'b1;
    run_op(C1, 0, 1'b0, res, lat, np);
    check("t6_data", res, P1);
    check("t6_lat", 128'(lat), 128'(87));
    spur_en = 1'b0;

    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      d = $urandom_range(0, 2);
      expand(key);
      ct = encrypt(pt);
      run_op(ct, d, 1'b0, res, lat, np);
      check("rand_data", res, pt);
      check("rand_lat", 128'(lat), 128'(87 + 11*d));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/aespim_inv_cipher.md
Name: aespim_inv_cipher

Overview:
- Iterative, column-serial AES inverse cipher (decryption engine) for the aespim accelerator.
- Takes one 128-bit ciphertext block and fetches round keys from an external key store via a request/valid handshake, last key first.
- Returns the plaintext block.
- Processes one 32-bit column per cycle through four aespim_bSbox instances driven with encrypt=0.

Parameters:
NR, 10, number of cipher rounds; legal values 10/12/14; first round key fetched is index NR.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  start request; accepted only when ready_o=1
data_i  input  128  ciphertext; sampled on the accepting edge
ready_o  output  1  high in IDLE; low while busy
rk_req_o  output  1  round-key request; held until served
rk_idx_o  output  4  requested round-key index (NR..0)
rk_i  input  128  round key data
rk_valid_i  input  1  rk_i valid; the key is consumed on any cycle where rk_req_o & rk_valid_i (same-cycle service allowed)
data_o  output  128  plaintext; held stable from valid_o until the next accepted start
valid_o  output  1  single-cycle pulse when data_o updates

Behaviour:
- Byte order per FIPS-197: state byte s[r][c] = data[127-8*(4c+r) -: 8]; column c = data[127-32c -: 32].
- Reset values (async, rst_ni=0): state=IDLE, ready_o=1, rk_req_o=0, rk_idx_o=0, data_o=0, valid_o=0, state register=0.
- Reset mid-operation aborts immediately and leaves no residue; the next start behaves as from power-up.
- FSM states: IDLE, ARK, SUB, MIX, DONE.
- IDLE:
  - start_i accepted: load data_i, set round counter rnd=NR, go to ARK.
  - start_i while busy is ignored; it is not queued.
- ARK:
  - rk_req_o=1, rk_idx_o=rnd.
  - On handshake: state ^= rk_i.
  - Next state: if rnd==NR, decrement rnd and go to SUB; else if rnd==0, go to DONE; else go to MIX.
  - Without handshake, stay in ARK; each such stall adds exactly one cycle.
- SUB:
  - 4 cycles, column counter k=0..3.
  - Output column k byte r = InvSbox(s[r][(k-r) mod 4]) for r=0..3 (InvShiftRows folded in).
  - Results are written to a shadow buffer; the buffer is committed to the state on k=3.
  - Then go to ARK.
- MIX:
  - 4 cycles, column k=0..3, applying InvMixColumns in place with coefficients {0e,0b,0d,09} over GF(2^8) mod 0x11B (xtime reduction constant 0x1B).
  - On k=3: decrement rnd, go to SUB.
- DONE (1 cycle):
  - data_o <= state, valid_o=1.
  - Next cycle returns to IDLE; ready_o is high again in IDLE.
- Latency with rk_valid_i tied high, NR=10:
  - 1 (initial ARK) + 9x(4 SUB + 1 ARK + 4 MIX) + (4 SUB + 1 ARK) = 87 cycles from the accepting edge to the edge that updates data_o. valid_o is high during the following cycle.
  - General formula: 9*NR-3 cycles plus one per ARK stall.
- The final round has no MIX.
- rk_valid_i while rk_req_o=0 is ignored.
- rk_i is sampled only on the handshake cycle and may change at any other time.
- start_i asserted in the same cycle as DONE is ignored; ready_o is low in DONE.
- A start accepted in IDLE while data_o still holds the previous result keeps data_o unchanged until the next valid_o.

Test Plan:
1. Key 2b7e151628aed2a6abf7158809cf4f3c, round-key ROM answering same-cycle, ct 3925841d02dc09fbdc118597196a0b32 -> data_o 3243f6a8885a308d313198a2e0370734, valid_o exactly 87 cycles after accept, single pulse.
2. Key 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5), ct 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff; rk_idx_o sequence observed as 10,9,...,0.
3. All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> 000...0. rk_valid_i delayed 3 cycles on every request -> same data_o, latency 87+11*3=120.
4. start_i pulsed at cycles 5 and 40 of an operation, and in the DONE cycle -> ignored; exactly one valid_o; data_o matches the first block only. Back-to-back start in IDLE right after DONE -> accepted.
5. rst_ni low at cycle 30 of vector 1 -> ready_o=1, rk_req_o=0, data_o=0 immediately. A new start with vector 2 -> correct result at 87 cycles.
6. Spurious rk_valid_i pulses while rk_req_o=0, with rk_i=ffff...ff -> result of vector 1 unaffected.
